paddle_scan_ctrl: RTL and testbench

PADDLE_SCAN_CTRL -- requirements
Module: paddle_scan_ctrl

---
 rtl/paddle_scan_pkg.sv | 22 ++
 rtl/paddle_scan_ctrl_rr_arbiter.sv | 41 ++++
 rtl/paddle_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_paddle_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_scan_pkg.sv
// Shared definitions for the paddle ADC scan controller and its SPI engine:
// FSM state encoding, ADC/result widths and channel-index helpers.
package paddle_scan_pkg;

    localparam int ADC_W  = 12;
    localparam int RES_W  = 10;
    localparam int CHAN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } scan_state_e;

    // Channel after chan, wrapping from nchan-1 back to 0.
    function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] chan,
                                                    input int nchan);
        return (int'(chan) >= nchan - 1) ? '0 : chan + 1'b1;
    endfunction

endpackage

// File: rtl/paddle_scan_ctrl_rr_arbiter.sv
// Round-robin grant search: first set bit at or above ptr, otherwise the
// first set bit below ptr (i.e. an upward search that wraps to 0).
module rr_arbiter
    import paddle_scan_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      req_vec,
    input  logic [CHAN_W-1:0] ptr,
    output logic [CHAN_W-1:0] grant,
    output logic              valid
);

    logic              hi_hit;
    logic              lo_hit;
    logic [CHAN_W-1:0] hi_idx;
    logic [CHAN_W-1:0] lo_idx;

    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan: the lowest matching index in each half is written last.
        for (int c = N - 1; c >= 0; c--) begin
            if (req_vec[c]) begin
                if (CHAN_W'(c) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = CHAN_W'(c);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = CHAN_W'(c);
                end
            end
        end
        valid = hi_hit | lo_hit;
        grant = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/paddle_scan_ctrl.sv
// Schedules per-channel ADC conversions onto a single SPI ADC engine with
// round-robin fairness, a WAIT timeout, and registered one-cycle strobes.
module paddle_scan_ctrl
    import paddle_scan_pkg::*;
#(
    parameter int NCHAN   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCHAN-1:0]  req,
    input  logic [NCHAN-1:0]  en,
    output logic              spi_start,
    output logic [CHAN_W-1:0] spi_chan,
    input  logic              spi_done,
    input  logic [ADC_W-1:0]  spi_data,
    output logic              rd_valid,
    output logic [CHAN_W-1:0] rd_chan,
    output logic [RES_W-1:0]  rd_data,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    scan_state_e       state_q, state_d;
    logic [NCHAN-1:0]  pending_q, pending_d;
    logic [CHAN_W-1:0] ptr_q, ptr_d;
    logic [CHAN_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              spi_start_q, spi_start_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CHAN_W-1:0] rd_chan_q, rd_chan_d;
    logic [RES_W-1:0]  rd_data_q, rd_data_d;
    logic              timeout_q, timeout_d;
    logic              clr;
    logic [CHAN_W-1:0] arb_grant;
    logic              arb_valid;
    logic              unused_adc_lsbs;

    assign unused_adc_lsbs = ^spi_data[ADC_W-RES_W-1:0];

    rr_arbiter #(.N(NCHAN)) u_arb (
        .req_vec (pending_q & en),
        .ptr     (ptr_q),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        clr         = 1'b0;
        spi_start_d = 1'b0;
        rd_valid_d  = 1'b0;
        timeout_d   = 1'b0;
        rd_chan_d   = rd_chan_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_grant;
                    spi_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_done) begin
                    rd_valid_d = 1'b1;
                    rd_chan_d  = grant_q;
                    rd_data_d  = spi_data[ADC_W-1:ADC_W-RES_W];
                    state_d    = ST_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    clr       = 1'b1;
                    ptr_d     = next_chan(grant_q, NCHAN);
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                clr     = 1'b1;
                ptr_d   = next_chan(grant_q, NCHAN);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A request arriving in the clearing cycle survives the clear.
        pending_d = (pending_q & ~(clr ? ({{(NCHAN-1){1'b0}}, 1'b1} << grant_q) : '0)) | req;
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            spi_start_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_chan_q   <= '0;
            rd_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            spi_start_q <= spi_start_d;
            rd_valid_q  <= rd_valid_d;
            rd_chan_q   <= rd_chan_d;
            rd_data_q   <= rd_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign spi_start   = spi_start_q;
    assign spi_chan    = grant_q;
    assign rd_valid    = rd_valid_q;
    assign rd_chan     = rd_chan_q;
    assign rd_data     = rd_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_paddle_scan_ctrl.sv
// Scoreboard bench for paddle_scan_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_paddle_scan_ctrl;

    localparam int NCHAN   = 4;
    localparam int TIMEOUT = 64;
    // spi_start cycle, then 64 WAIT cycles, then the registered pulse.
    localparam int TO_LAT  = 65;

    logic             clk;
    logic             reset;
    logic [NCHAN-1:0] req;
    logic [NCHAN-1:0] en;
    logic             spi_start;
    logic [2:0]       spi_chan;
    logic             spi_done;
    logic [11:0]      spi_data;
    logic             rd_valid;
    logic [2:0]       rd_chan;
    logic [9:0]       rd_data;
    logic             timeout_err;

    paddle_scan_ctrl #(.NCHAN(NCHAN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .en          (en),
        .spi_start   (spi_start),
        .spi_chan    (spi_chan),
        .spi_done    (spi_done),
        .spi_data    (spi_data),
        .rd_valid    (rd_valid),
        .rd_chan     (rd_chan),
        .rd_data     (rd_data),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_START, EV_RESULT, EV_TIMEOUT} ev_e;
    typedef struct {
        ev_e kind;
        int  chan;
        int  data;
    } ev_t;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_results = 0;
    int   last_start_cyc = 0;
    int   done_edge = 0;
    bit   eng_respond = 1'b1;
    int   eng_delay = 16;
    logic [11:0] eng_data = 12'h000;
    int   stray_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_e k, input int ch, input int d);
        ev_t e;
        e.kind = k;
        e.chan = ch;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_e k, input int ch, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d chan %0d, expected none (cycle %0d)", k, ch, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (e.kind != EV_TIMEOUT) check("event_chan", ch, e.chan);
            if (e.kind == EV_RESULT)  check("result_data", d, e.data);
        end
    endtask

    // Monitor: compares every strobe against the head of the scoreboard.
    always @(negedge clk) begin
        if (timeout_err === 1'b1) begin
            observe(EV_TIMEOUT, 0, 0);
            check("timeout_latency", cyc - last_start_cyc, TO_LAT);
        end
        if (rd_valid === 1'b1) begin
            n_results++;
            observe(EV_RESULT, rd_chan, rd_data);
            check("result_latency", cyc, done_edge);
        end
        if (spi_start === 1'b1) begin
            last_start_cyc = cyc;
            observe(EV_START, spi_chan, 0);
        end
    end

    // SPI engine model: answers each spi_start after eng_delay cycles.
    int stray_done = 0;
    initial begin
        spi_done = 1'b0;
        spi_data = 12'h000;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                spi_done   = 1'b1;
                spi_data   = 12'hABC;
                @(negedge clk);
                spi_done   = 1'b0;
            end else if (spi_start === 1'b1 && eng_respond) begin
                repeat (eng_delay) @(negedge clk);
                spi_done  = 1'b1;
                spi_data  = eng_data;
                done_edge = cyc + 1;
                @(negedge clk);
                spi_done  = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (10) step();
    endtask

    task automatic wait_results(input int target, input int budget);
        int n = 0;
        while (n_results < target && n < budget) begin
            step();
            n++;
        end
        check("results_reached", n_results, target);
    endtask

    task automatic check_outputs_reset();
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_chan", spi_chan, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_chan", rd_chan, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_timeout_err", timeout_err, 0);
    endtask

    initial begin
        int req_edge;
        int base;
        int n;
        reset = 1'b0;
        req   = '0;
        en    = '0;

        // Reset state
        do_reset();
        check_outputs_reset();

        // Single request, engine answers 12'hABC after 16 cycles
        en = 4'b1111; eng_respond = 1'b1; eng_delay = 16; eng_data = 12'hABC;
        push(EV_START, 2, 0);
        push(EV_RESULT, 2, 10'h2AF);
        req = 4'b0100;
        req_edge = cyc + 1;
        step();
        req = '0;
        wait_drain("single", 100);
        check("start_latency", last_start_cyc, req_edge + 1);
        check("hold_rd_data", rd_data, 10'h2AF);
        check("hold_rd_chan", rd_chan, 2);
        check("hold_spi_chan", spi_chan, 2);

        // Fairness with req held: 0,1,2,3 x2, then the four still pending
        do_reset();
        en = 4'b1111; eng_delay = 2; eng_data = 12'h3FC;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCHAN; c++) begin
                push(EV_START, c, 0);
                push(EV_RESULT, c, 10'h0FF);
            end
        base = n_results;
        req = 4'b1111;
        wait_results(base + 8, 300);
        step();
        req = '0;
        wait_drain("fair", 200);

        // Enable mask: only 0 and 2, then 3 (ptr=3) and 1 once enabled
        do_reset();
        en = 4'b0101; eng_delay = 3; eng_data = 12'h004;
        push(EV_START, 0, 0);
        push(EV_RESULT, 0, 10'h001);
        push(EV_START, 2, 0);
        push(EV_RESULT, 2, 10'h001);
        req = 4'b1111;
        step();
        req = '0;
        wait_drain("mask_a", 100);
        push(EV_START, 3, 0);
        push(EV_RESULT, 3, 10'h001);
        push(EV_START, 1, 0);
        push(EV_RESULT, 1, 10'h001);
        en = 4'b1111;
        wait_drain("mask_b", 100);

        // Timeout: engine silent, channels 0 then 1 are each abandoned
        do_reset();
        en = 4'b1111; eng_respond = 1'b0;
        push(EV_START, 0, 0);
        push(EV_TIMEOUT, 0, 0);
        push(EV_START, 1, 0);
        push(EV_TIMEOUT, 1, 0);
        req = 4'b0011;
        step();
        req = '0;
        wait_drain("timeout", 300);

        // Reset while in WAIT, then a stray spi_done
        do_reset();
        push(EV_START, 2, 0);
        req = 4'b0100;
        step();
        req = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("wait_reached", exp_q.size(), 0);
        repeat (5) step();
        do_reset();
        check_outputs_reset();
        stray_cnt++;
        repeat (80) step();
        check_outputs_reset();

        // Set-wins: req[1] during channel 1's CAPTURE cycle
        do_reset();
        eng_respond = 1'b1; eng_delay = 3; eng_data = 12'hFFF;
        push(EV_START, 1, 0);
        push(EV_RESULT, 1, 10'h3FF);
        push(EV_START, 1, 0);
        push(EV_RESULT, 1, 10'h3FF);
        req = 4'b0010;
        step();
        req = '0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("capture_seen", rd_valid, 1);
        req = 4'b0010;
        step();
        req = '0;
        wait_drain("set_wins", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
